// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and its neighbours: the
// bypass and register-file blocks use the same register-index width, r0 constant
// and default mult/div latency.
// Contents:
//   RegIdxW          register index width (5)
//   reg_idx_t        register index type
//   RegZero          r0 (hardwired zero, never a hazard source)
//   MdLatencyDefault default mult/div issue-to-ready latency
//   reg_match()      dependency compare that ignores r0 and unused operands
package hazard_stall_ctrl_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef logic [RegIdxW-1:0] reg_idx_t;

  localparam reg_idx_t RegZero = '0;

  localparam int unsigned MdLatencyDefault = 32;

  // A write to r0 is discarded, so nothing can depend on it.
  function automatic logic reg_match(reg_idx_t src, logic used, reg_idx_t dest);
    return used && (src == dest) && (dest != RegZero);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller.
// Decode (F/D) side: fd_valid, fd_rs1/fd_rs2 + used bits, fd_dest, fd_we,
//   fd_is_load, fd_is_md; pipeline control: flush, mw_we.
// Controller outputs: stall_fd (freeze PC and F/D), bubble_de (nop into D/X),
//   md_busy/md_dest (outstanding mult/div), md_wb (mult/div owns the RF write port).
// master: pipeline driving the decode side; slave: the controller.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic     fd_valid;
  reg_idx_t fd_rs1;
  reg_idx_t fd_rs2;
  logic     fd_rs1_used;
  logic     fd_rs2_used;
  reg_idx_t fd_dest;
  logic     fd_we;
  logic     fd_is_load;
  logic     fd_is_md;
  logic     flush;
  logic     mw_we;

  logic     stall_fd;
  logic     bubble_de;
  logic     md_busy;
  reg_idx_t md_dest;
  logic     md_wb;

  modport master (
    output fd_valid, fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used, fd_dest, fd_we,
           fd_is_load, fd_is_md, flush, mw_we,
    input  stall_fd, bubble_de, md_busy, md_dest, md_wb
  );

  modport slave (
    input  fd_valid, fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used, fd_dest, fd_we,
           fd_is_load, fd_is_md, flush, mw_we,
    output stall_fd, bubble_de, md_busy, md_dest, md_wb
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_tracker.sv
// Tracks the single outstanding mult/div operation and arbitrates its result
// onto the register-file write port.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   issue_md_i   a mult/div is issuing into D/X this cycle
//   issue_dest_i its destination register
//   mw_we_i      M/W stage owns the write port this cycle (has priority)
//   md_busy_o    operation outstanding (set at issue, cleared by md_wb)
//   md_dest_o    destination of the outstanding operation
//   md_wb_o      result is written to the register file this cycle
module hazard_stall_ctrl_md_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MdLatencyDefault,
  parameter int unsigned CNT_W      = 6
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     issue_md_i,
  input  reg_idx_t issue_dest_i,
  input  logic     mw_we_i,
  output logic     md_busy_o,
  output reg_idx_t md_dest_o,
  output logic     md_wb_o
);

  logic             busy_q, busy_d;
  logic             pending_q, pending_d;
  reg_idx_t         dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    md_wb_o   = pending_q & ~mw_we_i;

    if (md_wb_o) begin
      busy_d    = 1'b0;
      pending_d = 1'b0;
    end else if (busy_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Raise pending together with the count reaching zero so the result can
      // be written in the MD_LATENCY-th busy cycle.
      if (cnt_q == CNT_W'(1)) begin
        pending_d = 1'b1;
      end
    end

    // The structural stall keeps a new mult/div from issuing while busy.
    if (issue_md_i) begin
      busy_d    = 1'b1;
      pending_d = 1'b0;
      dest_d    = issue_dest_i;
      cnt_d     = CNT_W'(MD_LATENCY - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      dest_q    <= '0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
    end
  end

  assign md_busy_o = busy_q;
  assign md_dest_o = dest_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: detects hazards the execute-stage bypass cannot
// resolve (load-use at distance 1, operands still in the multicycle mult/div
// unit) and stalls issue until the value exists.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, clears all state
//   bus    hazard_stall_ctrl_if.slave: F/D instruction fields, flush, mw_we in;
//          stall_fd, bubble_de, md_busy, md_dest, md_wb out
// MD_LATENCY must be at least 2 and 2**CNT_W must exceed it.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MdLatencyDefault,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_stall_ctrl_if.slave   bus
);

  // D/X copy of the instruction that issued last cycle.
  logic     de_valid_q, de_valid_d;
  reg_idx_t de_dest_q, de_dest_d;
  logic     de_we_q, de_we_d;
  logic     de_is_load_q, de_is_load_d;

  logic     load_use;
  logic     md_hazard;
  logic     stall;
  logic     issue;
  logic     md_busy;
  reg_idx_t md_dest;
  logic     md_wb;

  always_comb begin
    load_use = de_valid_q & de_is_load_q & de_we_q &
               (reg_match(bus.fd_rs1, bus.fd_rs1_used, de_dest_q) |
                reg_match(bus.fd_rs2, bus.fd_rs2_used, de_dest_q));

    // The result is never forwarded, so readers, writers (WAW) and any other
    // mult/div all wait for md_wb.
    md_hazard = md_busy & bus.fd_valid &
                (reg_match(bus.fd_rs1, bus.fd_rs1_used, md_dest) |
                 reg_match(bus.fd_rs2, bus.fd_rs2_used, md_dest) |
                 reg_match(bus.fd_dest, bus.fd_we, md_dest) |
                 bus.fd_is_md);

    // Flush kills F/D anyway, so it overrides the stall.
    stall = (load_use | md_hazard) & ~bus.flush;
    issue = bus.fd_valid & ~stall & ~bus.flush;
  end

  always_comb begin
    de_valid_d   = issue;
    de_dest_d    = de_dest_q;
    de_we_d      = de_we_q;
    de_is_load_d = de_is_load_q;
    if (issue) begin
      de_dest_d    = bus.fd_dest;
      de_we_d      = bus.fd_we;
      de_is_load_d = bus.fd_is_load;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_valid_q   <= 1'b0;
      de_dest_q    <= '0;
      de_we_q      <= 1'b0;
      de_is_load_q <= 1'b0;
    end else begin
      de_valid_q   <= de_valid_d;
      de_dest_q    <= de_dest_d;
      de_we_q      <= de_we_d;
      de_is_load_q <= de_is_load_d;
    end
  end

  hazard_stall_ctrl_md_tracker #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_md_i   (issue & bus.fd_is_md),
    .issue_dest_i (bus.fd_dest),
    .mw_we_i      (bus.mw_we),
    .md_busy_o    (md_busy),
    .md_dest_o    (md_dest),
    .md_wb_o      (md_wb)
  );

  assign bus.stall_fd  = stall;
  assign bus.bubble_de = stall | bus.flush;
  assign bus.md_busy   = md_busy;
  assign bus.md_dest   = md_dest;
  assign bus.md_wb     = md_wb;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] dest;
    logic       we;
    logic       ld;
    logic       md;
    logic       flush;
    logic       mw;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       busy;
    logic       wb;
    logic [4:0] dest;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  out_t sb[$];

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .MD_LATENCY (4),
    .CNT_W      (6)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t ins(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] dest, logic we, logic ld, logic md);
    stim_t s = '0;
    s.v = 1'b1; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.dest = dest; s.we = we; s.ld = ld; s.md = md;
    return s;
  endfunction

  function automatic stim_t with_flush(stim_t s);
    stim_t r = s;
    r.flush = 1'b1;
    return r;
  endfunction

  function automatic stim_t with_mw(stim_t s);
    stim_t r = s;
    r.mw = 1'b1;
    return r;
  endfunction

  function automatic stim_t with_rst(stim_t s);
    stim_t r = s;
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic out_t o(logic stall, logic bubble, logic busy, logic wb, logic [4:0] dest);
    out_t r;
    r.stall = stall; r.bubble = bubble; r.busy = busy; r.wb = wb; r.dest = dest;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.stall = bus.stall_fd; r.bubble = bus.bubble_de; r.busy = bus.md_busy;
    r.wb = bus.md_wb; r.dest = bus.md_dest;
    return r;
  endfunction

  task automatic drive(stim_t s);
    bus.fd_valid = s.v;       bus.fd_rs1 = s.rs1;     bus.fd_rs1_used = s.u1;
    bus.fd_rs2 = s.rs2;       bus.fd_rs2_used = s.u2; bus.fd_dest = s.dest;
    bus.fd_we = s.we;         bus.fd_is_load = s.ld;  bus.fd_is_md = s.md;
    bus.flush = s.flush;      bus.mw_we = s.mw;       rst = s.rst;
  endtask

  task automatic do_reset();
    drive(with_rst('0));
    @(posedge clk); #1;
    drive('0);
  endtask

  // Common instructions
  stim_t nop_s;
  stim_t lw5, add6_r5, mul7, cons7;
  initial begin
    nop_s   = '0;
    lw5     = ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    add6_r5 = ins(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    mul7    = ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    cons7   = ins(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
  end

  task automatic test_reset();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(nop_s);   ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(add6_r5); ex.push_back(o(0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(lw5);     ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(add6_r5); ex.push_back(o(1, 1, 0, 0, 0));
    st.push_back(add6_r5); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(ins(5'd2, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(o(1, 1, 0, 0, 0));
    st.push_back(ins(5'd2, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    // rs1 matches the load but is not used by this instruction
    st.push_back(ins(5'd8, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL load_use[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r0();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0)); ex.push_back(o(0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL r0[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  // md_dest is only meaningful while md_busy; it is masked when busy is expected low.
  task automatic test_md_dep();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(mul7);  ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(cons7); ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7); ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7); ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7); ex.push_back(o(1, 1, 1, 1, 7));
    st.push_back(cons7); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(nop_s); ex.push_back(o(0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      if (!e.busy) g.dest = '0;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL md_dep[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wb_conflict();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(mul7);           ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(cons7);          ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7);          ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7);          ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(with_mw(cons7)); ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(with_mw(cons7)); ex.push_back(o(1, 1, 1, 0, 7));
    st.push_back(cons7);          ex.push_back(o(1, 1, 1, 1, 7));
    st.push_back(cons7);          ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(nop_s);          ex.push_back(o(0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      if (!e.busy) g.dest = '0;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL wb_conflict[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_struct_waw();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    stim_t mul3, div4, addi9, addi3;
    mul3  = ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    div4  = ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    addi9 = ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    addi3 = ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    do_reset();
    st.push_back(mul3);  ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(addi9); ex.push_back(o(0, 0, 1, 0, 3));
    st.push_back(addi3); ex.push_back(o(1, 1, 1, 0, 3));
    st.push_back(addi3); ex.push_back(o(1, 1, 1, 0, 3));
    st.push_back(addi3); ex.push_back(o(1, 1, 1, 1, 3));
    st.push_back(addi3); ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(mul3);  ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(div4);  ex.push_back(o(1, 1, 1, 0, 3));
    st.push_back(div4);  ex.push_back(o(1, 1, 1, 0, 3));
    st.push_back(div4);  ex.push_back(o(1, 1, 1, 0, 3));
    st.push_back(div4);  ex.push_back(o(1, 1, 1, 1, 3));
    st.push_back(div4);  ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(nop_s); ex.push_back(o(0, 0, 1, 0, 4));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      if (!e.busy) g.dest = '0;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL struct_waw[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_reset();
    stim_t st[$];
    out_t  ex[$];
    out_t  e, g;
    do_reset();
    st.push_back(lw5);                 ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(with_flush(add6_r5)); ex.push_back(o(0, 1, 0, 0, 0));
    st.push_back(add6_r5);             ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(mul7);                ex.push_back(o(0, 0, 0, 0, 0));
    st.push_back(with_flush(cons7));   ex.push_back(o(0, 1, 1, 0, 7));
    // Reset is synchronous: this cycle still shows the in-flight operation.
    st.push_back(with_rst(nop_s));     ex.push_back(o(0, 0, 1, 0, 7));
    for (int k = 0; k < 5; k++) begin
      st.push_back(nop_s);             ex.push_back(o(0, 0, 0, 0, 0));
    end
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL flush_reset[%0d]: got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (stall/bubble/busy/wb/dest)",
                 i, g.stall, g.bubble, g.busy, g.wb, g.dest, e.stall, e.bubble, e.busy, e.wb, e.dest);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(with_rst('0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_r0();
    test_md_dep();
    test_wb_conflict();
    test_struct_waw();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer-side companion to the execute-stage bypass logic. It detects hazards that forwarding cannot resolve and stalls issue until the value exists.
- Covers two cases: load-use distance of 1, and results still in flight in the multicycle mult/div unit.
- Tracks the D/X instruction and the single outstanding mult/div destination.
- Drives the F/D freeze and D/X bubble, and sequences mult/div writeback onto the register-file write port.

Parameters:
- MD_LATENCY, 32, cycles from mult/div issue to result ready (minimum 2).
- CNT_W, 6, mult/div counter width; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- fd_valid  in  1  F/D holds a real instruction.
- fd_rs1  in  5  first source register of F/D instruction.
- fd_rs2  in  5  second source register (rd for stores/branches, already selected upstream).
- fd_rs1_used  in  1  instruction reads rs1.
- fd_rs2_used  in  1  instruction reads rs2.
- fd_dest  in  5  destination register of F/D instruction.
- fd_we  in  1  F/D instruction writes a register.
- fd_is_load  in  1  F/D instruction is lw.
- fd_is_md  in  1  F/D instruction is mul/div.
- flush  in  1  taken branch/jump resolved in X; kills F/D and D/X.
- mw_we  in  1  M/W stage writes the register file this cycle.
- stall_fd  out  1  hold PC and F/D latch.
- bubble_de  out  1  load nop into D/X.
- md_busy  out  1  mult/div operation outstanding.
- md_dest  out  5  destination of outstanding mult/div.
- md_wb  out  1  mult/div result drives register-file write port this cycle.

Behaviour:
- Reset: all outputs are 0. de_valid=0, md_busy=0, counter=0, md_pending=0.
- Issue definition: issue = fd_valid & ~stall_fd & ~flush.
  - On issue, the internal D/X copy latches fd_dest, fd_we and fd_is_load, and de_valid=1.
  - Otherwise de_valid=0 (bubble).
- Register 0 never creates a hazard: any comparison against r0 is false.
- Load-use stall (combinational):
  - Fires when de_valid & de_is_load & de_we & de_dest!=0, and fd_rs1 or fd_rs2 matches de_dest (respecting its used bit).
  - Stall lasts exactly one cycle. The next cycle the load sits in X/M and bypass covers it.
- Mult/div hazard (combinational): stall while md_busy, fd_valid, and any of the following hold:
  - a used source equals md_dest (nonzero);
  - fd_dest==md_dest with fd_we (WAW);
  - fd_is_md (structural: single unit).
- Outputs: stall_fd = (load_use | md_hazard) & ~flush. bubble_de = stall_fd | flush.
- Flush priority: flush wins over stall in the same cycle. It does not cancel an in-flight mult/div; the counter keeps running.
- Mult/div counter:
  - On issue of fd_is_md: md_busy=1, md_dest=fd_dest, counter=MD_LATENCY-1.
  - While md_busy and counter!=0, the counter decrements each cycle.
  - When counter==0, md_pending=1.
- Mult/div writeback:
  - md_wb = md_pending & ~mw_we. Normal writeback has priority.
  - On a cycle with md_wb=1: md_busy=0, md_pending=0, and the dependent stall releases on the next cycle.
  - If mw_we stays high, md_wb is deferred indefinitely and md_busy remains 1.
- Result is not forwarded: consumers read the register file after md_wb. The register file is write-before-read, so a consumer can issue the cycle after md_wb.
- Mult/div issued with fd_dest==0: it still occupies the unit for MD_LATENCY cycles, and md_wb still pulses (the write to r0 is ignored by the register file).
- Reset mid-operation: everything clears the same cycle. An in-flight mult/div is dropped and md_wb never fires.

Decomposition:
- Shared include file holds the reg-index width constant (5), R0 constant, and MD_LATENCY default, also used by the bypass and register-file blocks.
- One sub-module: md_tracker. It contains the counter, md_busy, md_dest, md_pending and the md_wb arbitration.
- The top level holds the D/X copy and the stall equations.

Test Plan:
- Load-use: lw r5 issues, then add r6,r5,r1 in F/D.
  - Required: stall_fd=1 and bubble_de=1 for exactly 1 cycle; add issues the next cycle.
- r0 immunity: lw r0, then add r2,r0,r0.
  - Required: stall_fd never asserts.
- Mult/div dependence: mul r7 issued with MD_LATENCY=4, next instruction reads r7, mw_we=0.
  - Required: md_busy=1 for 4 cycles and md_wb=1 on the 4th; stall_fd high until md_wb; consumer issues the cycle after md_wb.
- Writeback conflict: same as the previous case but mw_we=1 on the ready cycle and the following cycle.
  - Required: md_wb is delayed 2 cycles; md_busy and stall stay high until md_wb=1.
- Structural/WAW: mul r3 in flight; div r4 in F/D.
  - Required: stall until md_wb. Separately, addi r3 (WAW) also stalls, while addi r9 does not stall.
- Flush and reset: a load-use stall coincides with flush=1.
  - Required: stall_fd=0, bubble_de=1.
  - Then assert reset mid-mult/div: next cycle all outputs are 0 and md_wb never fires.
